// File: rtl/top_pkg.sv
// Shared hue-sector types: sector enumeration, per-channel duty modes and the
// sector-to-(R,G,B) mode table used by the colour-wheel PWM.
package top_pkg;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } sector_e;

   typedef enum logic [1:0] {
      MODE_ZERO = 2'd0,
      MODE_MAX  = 2'd1,
      MODE_UP   = 2'd2,
      MODE_DOWN = 2'd3
   } mode_e;

   typedef struct packed {
      mode_e r;
      mode_e g;
      mode_e b;
   } rgb_mode_t;

   // Hue wheel: one channel ramps per sector while the others sit at rail values.
   function automatic rgb_mode_t sector_modes(sector_e s);
      rgb_mode_t m;
      m = '{r: MODE_ZERO, g: MODE_ZERO, b: MODE_ZERO};
      case (s)
         S0:      m = '{r: MODE_MAX,  g: MODE_UP,   b: MODE_ZERO};
         S1:      m = '{r: MODE_DOWN, g: MODE_MAX,  b: MODE_ZERO};
         S2:      m = '{r: MODE_ZERO, g: MODE_MAX,  b: MODE_UP};
         S3:      m = '{r: MODE_ZERO, g: MODE_DOWN, b: MODE_MAX};
         S4:      m = '{r: MODE_UP,   g: MODE_ZERO, b: MODE_MAX};
         S5:      m = '{r: MODE_MAX,  g: MODE_ZERO, b: MODE_DOWN};
         default: m = '{r: MODE_ZERO, g: MODE_ZERO, b: MODE_ZERO};
      endcase
      return m;
   endfunction

   function automatic sector_e next_sector(sector_e s);
      sector_e n;
      case (s)
         S0:      n = S1;
         S1:      n = S2;
         S2:      n = S3;
         S3:      n = S4;
         S4:      n = S5;
         default: n = S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output stage: compares the shared counter against a duty value and
// registers the active-low LED drive.
module pwm_channel #(
   parameter int unsigned CW = 11,
   parameter int unsigned DW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] pwm_cnt,
   input  logic [DW-1:0] duty,
   output logic          pin
);

   logic pin_q;
   logic pin_d;

   // Duty 0 never lights, duty == interval always lights.
   always_comb begin
      pin_d = ~(DW'(pwm_cnt) < duty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_q <= 1'b1;
      end else begin
         pin_q <= pin_d;
      end
   end

   assign pin = pin_q;

endmodule

// File: rtl/top.sv
// RGB colour-wheel generator: PWM counter, step counter and six-sector hue FSM
// drive three PWM channels through a full hue cycle of 6*N*N clocks.
module top
   import top_pkg::*;
#(
   parameter int unsigned PWM_INTERVAL = 1200
) (
   input  logic clk,
   input  logic rst,
   output logic RGB_R,
   output logic RGB_G,
   output logic RGB_B
);

   localparam int unsigned CW = $clog2(PWM_INTERVAL);
   localparam int unsigned DW = $clog2(PWM_INTERVAL + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);
   localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL);

   logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CW-1:0] step_q, step_d;
   sector_e       sector_q, sector_d;
   logic          cnt_wrap, step_wrap;
   rgb_mode_t     modes;
   logic [DW-1:0] duty_r, duty_g, duty_b;

   function automatic logic [DW-1:0] mode_duty(mode_e m, logic [CW-1:0] step);
      logic [DW-1:0] d;
      case (m)
         MODE_MAX:  d = DUTY_MAX;
         MODE_UP:   d = DW'(step);
         MODE_DOWN: d = DUTY_MAX - DW'(step);
         default:   d = '0;
      endcase
      return d;
   endfunction

   // Counters: step advances once per PWM period, each wrapping at the interval.
   always_comb begin
      cnt_wrap  = (pwm_cnt_q == CNT_LAST);
      step_wrap = (step_q == CNT_LAST);
      pwm_cnt_d = cnt_wrap ? '0 : pwm_cnt_q + CW'(1);
      step_d    = step_q;
      if (cnt_wrap) begin
         step_d = step_wrap ? '0 : step_q + CW'(1);
      end
   end

   // Sector FSM next state: advance only when both counters wrap together.
   always_comb begin
      sector_d = sector_q;
      if (cnt_wrap && step_wrap) begin
         sector_d = next_sector(sector_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         step_q    <= '0;
         sector_q  <= S0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         step_q    <= step_d;
         sector_q  <= sector_d;
      end
   end

   always_comb begin
      modes  = sector_modes(sector_q);
      duty_r = mode_duty(modes.r, step_q);
      duty_g = mode_duty(modes.g, step_q);
      duty_b = mode_duty(modes.b, step_q);
   end

   pwm_channel #(.CW(CW), .DW(DW)) u_ch_r (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt_q),
      .duty    (duty_r),
      .pin     (RGB_R)
   );

   pwm_channel #(.CW(CW), .DW(DW)) u_ch_g (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt_q),
      .duty    (duty_g),
      .pin     (RGB_G)
   );

   pwm_channel #(.CW(CW), .DW(DW)) u_ch_b (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt_q),
      .duty    (duty_b),
      .pin     (RGB_B)
   );

endmodule

// File: tb/tb_top.sv
// Bench for the colour-wheel PWM: three instances (N=8, N=13, default) checked
// every cycle against an arithmetic hue-wheel model, plus directed duty counts.
module tb_top;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic r8, g8, b8;
   logic r13, g13, b13;
   logic rd, gd, bd;

   int checks = 0;
   int failures = 0;
   int k = 0;
   logic [2:0] hist8 [0:1023];

   always #5 clk = ~clk;

   top #(.PWM_INTERVAL(8)) dut8 (
      .clk (clk), .rst (rst), .RGB_R (r8), .RGB_G (g8), .RGB_B (b8)
   );

   top #(.PWM_INTERVAL(13)) dut13 (
      .clk (clk), .rst (rst), .RGB_R (r13), .RGB_G (g13), .RGB_B (b13)
   );

   top dutd (
      .clk (clk), .rst (rst), .RGB_R (rd), .RGB_G (gd), .RGB_B (bd)
   );

   // Pins {R,G,B} seen k clocks after reset release for interval n.
   function automatic logic [2:0] model_pins(int n, int kk);
      int t, sec, st, cnt, dr, dg, db;
      t   = kk % (6 * n * n);
      sec = t / (n * n);
      st  = (t / n) % n;
      cnt = t % n;
      dr = 0; dg = 0; db = 0;
      case (sec)
         0: begin dr = n;      dg = st;     db = 0;      end
         1: begin dr = n - st; dg = n;      db = 0;      end
         2: begin dr = 0;      dg = n;      db = st;     end
         3: begin dr = 0;      dg = n - st; db = n;      end
         4: begin dr = st;     dg = 0;      db = n;      end
         default: begin dr = n; dg = 0;     db = n - st; end
      endcase
      return {(cnt >= dr), (cnt >= dg), (cnt >= db)};
   endfunction

   task automatic check3(input string tag, input int idx, input logic [2:0] obs,
                         input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, idx, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_off(input string tag);
      check3({tag, "_n8"},  k, {r8, g8, b8},    3'b111);
      check3({tag, "_n13"}, k, {r13, g13, b13}, 3'b111);
      check3({tag, "_def"}, k, {rd, gd, bd},    3'b111);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (k < 1024) hist8[k] = {r8, g8, b8};
         check3("n8",   k, {r8, g8, b8},    model_pins(8, k));
         check3("n13",  k, {r13, g13, b13}, model_pins(13, k));
         check3("ndef", k, {rd, gd, bd},    model_pins(1200, k));
         k++;
      end
   endtask

   // Low (lit) clocks of one channel over a window of the N=8 history; ch 2=R,1=G,0=B.
   function automatic int count_low(int ch, int from, int len);
      int c;
      logic [2:0] v;
      c = 0;
      for (int i = from; i < from + len; i++) begin
         v = hist8[i];
         if (v[ch] == 1'b0) c++;
      end
      return c;
   endfunction

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      k = 0;
   endtask

   initial begin
      int run_len;
      int dly;
      // Power-on reset holds all LEDs off.
      repeat (3) @(posedge clk);
      #1;
      check_all_off("por");
      release_reset();

      // Run into S3 step 4 of the N=8 instance.
      run_cycles(228);
      check3("first_edge", 0, hist8[0], 3'b011);
      check_int("s0_step3_r_low", count_low(2, 24, 8), 8);
      check_int("s0_step3_g_low", count_low(1, 24, 8), 3);
      check_int("s0_step3_b_low", count_low(0, 24, 8), 0);
      check_int("s1_step0_r_low", count_low(2, 64, 8), 8);
      check_int("s1_step7_r_low", count_low(2, 120, 8), 1);
      check_int("s2_step0_r_low", count_low(2, 128, 8), 0);
      check_int("s3_step4_b_low", count_low(0, 224, 4), 4);

      // Mid-run asynchronous reset: outputs go off without a clock edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_off("async_rst");
      @(posedge clk);
      #1;
      check_all_off("rst_held");
      release_reset();

      // Restart from S0 step 0 and cover one full N=8 and N=13 hue cycle.
      run_cycles(1100);
      check3("restart_first_edge", 0, hist8[0], 3'b011);
      check3("wrap_to_s0", 384, hist8[384], 3'b011);
      check_int("wrap_s0_step3_g_low", count_low(1, 384 + 24, 8), 3);
      check_int("s5_last_b_low", count_low(0, 376, 8), 1);

      // Randomly placed resets, sub-cycle phase included.
      for (int r = 0; r < 4; r++) begin
         run_len = int'($urandom_range(1, 500));
         dly = int'($urandom_range(1, 3));
         run_cycles(run_len);
         @(negedge clk);
         #(dly);
         rst = 1'b1;
         #1;
         check_all_off("rand_rst");
         @(posedge clk);
         #1;
         check_all_off("rand_rst_held");
         release_reset();
      end
      run_cycles(600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
